// File: rtl/f_pc_reg.sv
// Fetch-stage program counter: static branch prediction, redirect/stall
// arbitration, legality checks on every PC, and a sticky halt with a cause code.
module f_pc_reg #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_LO    = 32'h8000_0000,
   parameter logic [31:0] PC_HI    = 32'h87FF_FFFF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [6:0]  f_opcode_i,
   input  logic [31:0] f_imm_i,
   input  logic [31:0] f_default_pc_i,
   input  logic        f_imem_error_i,
   output logic [31:0] F_pc_o,
   output logic        f_valid_o,
   output logic        pred_taken_o,
   output logic [1:0]  state_o,
   output logic [1:0]  err_code_o,
   output logic [31:0] fetch_cnt_o
);

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_IMEM  = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_ALIGN = 2'd3;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic        pred_taken;
   logic [31:0] pred_pc;
   logic [31:0] sel_pc;
   logic        sel_misaligned;
   logic        sel_out_of_range;
   logic        default_bad;

   // Static predictor: JAL always taken, branches taken only when backward.
   assign pred_taken = (f_opcode_i == OP_JAL) ||
                       ((f_opcode_i == OP_BRANCH) && f_imm_i[31]);
   assign pred_pc    = pred_taken ? (pc_q + f_imm_i) : f_default_pc_i;

   // Redirect beats stall, stall beats prediction.
   assign sel_pc = redirect_valid_i ? redirect_pc_i :
                   stall_i          ? pc_q          : pred_pc;

   assign sel_misaligned   = (sel_pc[1:0] != 2'b00);
   assign sel_out_of_range = (sel_pc < PC_LO) || (sel_pc > PC_HI);
   // Fetch reports an out-of-range PC as a zero PC+4; a redirect supersedes it.
   assign default_bad      = !redirect_valid_i && (f_default_pc_i == 32'd0);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      err_d       = err_q;
      fetch_cnt_d = fetch_cnt_q;
      case (state_q)
         ST_INIT: state_d = ST_RUN;
         ST_RUN: begin
            if (f_imem_error_i) begin
               err_d   = ERR_IMEM;
               state_d = ST_HALT;
            end else if (sel_misaligned) begin
               err_d   = ERR_ALIGN;
               state_d = ST_HALT;
            end else if (sel_out_of_range || default_bad) begin
               err_d   = ERR_RANGE;
               state_d = ST_HALT;
            end else begin
               pc_d = sel_pc;
               if (!redirect_valid_i && !stall_i) begin
                  fetch_cnt_d = fetch_cnt_q + 32'd1;
               end
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_INIT;
         pc_q        <= RESET_PC;
         err_q       <= ERR_NONE;
         fetch_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         err_q       <= err_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign F_pc_o       = pc_q;
   assign f_valid_o    = (state_q == ST_RUN);
   assign pred_taken_o = pred_taken;
   assign state_o      = state_q;
   assign err_code_o   = err_q;
   assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_f_pc_reg.sv
// Directed bench for f_pc_reg: sequential fetch, prediction, stall/redirect,
// halt causes and priority, asynchronous reset and fetch counter wrap.
module tb_f_pc_reg;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [6:0]  opcode;
   logic [31:0] imm;
   logic [31:0] default_pc;
   logic        imem_err;
   logic [31:0] pc;
   logic        valid;
   logic        pred;
   logic [1:0]  state;
   logic [1:0]  err;
   logic [31:0] cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;

   localparam logic [6:0] OP_ALU = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BR  = 7'b1100011;

   f_pc_reg dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .stall_i          (stall),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .f_opcode_i       (opcode),
      .f_imm_i          (imm),
      .f_default_pc_i   (default_pc),
      .f_imem_error_i   (imem_err),
      .F_pc_o           (pc),
      .f_valid_o        (valid),
      .pred_taken_o     (pred),
      .state_o          (state),
      .err_code_o       (err),
      .fetch_cnt_o      (cnt)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_seq(input logic [31:0] cur);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      opcode         = OP_ALU;
      imm            = 32'd0;
      default_pc     = cur + 32'd4;
      imem_err       = 1'b0;
   endtask

   // Reset asserted away from the edge, released on a falling edge; then one
   // edge takes the FSM from INIT to RUN.
   task automatic reset_to_run();
      drive_seq(32'h8000_0000);
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      exp_pc  = 32'h8000_0000;
      exp_cnt = 32'd0;
   endtask

   task automatic test_reset();
      drive_seq(32'h8000_0000);
      rst_n = 1'b0;
      #12;
      checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (err !== 2'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err); end
      checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
   endtask

   task automatic test_sequential();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (pc !== 32'h8000_0000 || valid !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL seq_init got pc=%h v=%b st=%0d exp pc=80000000 v=0 st=0", pc, valid, state); end
      tick();
      checks++; if (pc !== 32'h8000_0000 || valid !== 1'b1 || state !== 2'd1) begin errors++; $display("FAIL seq_run got pc=%h v=%b st=%0d exp pc=80000000 v=1 st=1", pc, valid, state); end
      drive_seq(32'h8000_0000);
      tick();
      checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc1 got=%h exp=80000004", pc); end
      drive_seq(32'h8000_0004);
      tick();
      checks++; if (pc !== 32'h8000_0008 || cnt !== 32'd2) begin errors++; $display("FAIL seq_pc2 got pc=%h cnt=%0d exp pc=80000008 cnt=2", pc, cnt); end
      exp_pc  = 32'h8000_0008;
      exp_cnt = 32'd2;
      for (int i = 0; i < 2; i++) begin
         drive_seq(exp_pc);
         tick();
         exp_pc  = exp_pc + 32'd4;
         exp_cnt = exp_cnt + 32'd1;
      end
      checks++; if (pc !== 32'h8000_0010 || cnt !== 32'd4) begin errors++; $display("FAIL seq_pc4 got pc=%h cnt=%0d exp pc=80000010 cnt=4", pc, cnt); end
   endtask

   task automatic test_predict();
      // Backward branch at 8000_0010
      drive_seq(32'h8000_0010);
      opcode = OP_BR;
      imm    = 32'hFFFF_FFF0;
      #1;
      checks++; if (pred !== 1'b1) begin errors++; $display("FAIL pred_back_branch got=%b exp=1", pred); end
      tick();
      checks++; if (pc !== 32'h8000_0000 || cnt !== 32'd5) begin errors++; $display("FAIL back_branch_pc got pc=%h cnt=%0d exp pc=80000000 cnt=5", pc, cnt); end
      exp_pc  = 32'h8000_0000;
      exp_cnt = 32'd5;
      for (int i = 0; i < 4; i++) begin
         drive_seq(exp_pc);
         tick();
         exp_pc  = exp_pc + 32'd4;
         exp_cnt = exp_cnt + 32'd1;
      end
      checks++; if (pc !== 32'h8000_0010 || cnt !== 32'd9) begin errors++; $display("FAIL rewalk_pc got pc=%h cnt=%0d exp pc=80000010 cnt=9", pc, cnt); end
      // JAL at 8000_0010
      drive_seq(32'h8000_0010);
      opcode = OP_JAL;
      imm    = 32'h20;
      #1;
      checks++; if (pred !== 1'b1) begin errors++; $display("FAIL pred_jal got=%b exp=1", pred); end
      tick();
      checks++; if (pc !== 32'h8000_0030 || cnt !== 32'd10) begin errors++; $display("FAIL jal_pc got pc=%h cnt=%0d exp pc=80000030 cnt=10", pc, cnt); end
      // Forward branch: not taken, falls through to PC+4
      drive_seq(32'h8000_0030);
      opcode = OP_BR;
      imm    = 32'h0000_0008;
      #1;
      checks++; if (pred !== 1'b0) begin errors++; $display("FAIL pred_fwd_branch got=%b exp=0", pred); end
      // Negative immediate on a non-branch opcode must not predict taken
      opcode = OP_ALU;
      imm    = 32'hFFFF_FFF0;
      #1;
      checks++; if (pred !== 1'b0) begin errors++; $display("FAIL pred_alu_negimm got=%b exp=0", pred); end
      opcode = OP_BR;
      imm    = 32'h0000_0008;
      tick();
      checks++; if (pc !== 32'h8000_0034 || cnt !== 32'd11) begin errors++; $display("FAIL fwd_branch_pc got pc=%h cnt=%0d exp pc=80000034 cnt=11", pc, cnt); end
   endtask

   task automatic test_stall_redirect();
      drive_seq(32'h8000_0034);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pc !== 32'h8000_0034 || cnt !== 32'd11) begin errors++; $display("FAIL stall_hold%0d got pc=%h cnt=%0d exp pc=80000034 cnt=11", i, pc, cnt); end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      tick();
      checks++; if (pc !== 32'h8000_0100 || cnt !== 32'd11 || state !== 2'd1) begin errors++; $display("FAIL stall_redirect got pc=%h cnt=%0d st=%0d exp pc=80000100 cnt=11 st=1", pc, cnt, state); end
      // Legal redirect masks a zero default PC
      drive_seq(32'h8000_0100);
      default_pc     = 32'd0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      tick();
      checks++; if (pc !== 32'h8000_0200 || state !== 2'd1 || err !== 2'd0) begin errors++; $display("FAIL redirect_mask got pc=%h st=%0d err=%0d exp pc=80000200 st=1 err=0", pc, state, err); end
      // Redirect to the top legal word is accepted
      drive_seq(32'h8000_0200);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h87FF_FFFC;
      tick();
      checks++; if (pc !== 32'h87FF_FFFC || state !== 2'd1) begin errors++; $display("FAIL redirect_hi got pc=%h st=%0d exp pc=87fffffc st=1", pc, state); end
      drive_seq(32'h87FF_FFFC);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      tick();
   endtask

   task automatic test_misaligned();
      drive_seq(32'h8000_0200);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd3 || pc !== 32'h8000_0200 || valid !== 1'b0) begin errors++; $display("FAIL misaligned_halt got st=%0d err=%0d pc=%h v=%b exp st=2 err=3 pc=80000200 v=0", state, err, pc, valid); end
      redirect_pc = 32'h8000_0300;
      tick();
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd3 || pc !== 32'h8000_0200 || cnt !== 32'd11) begin errors++; $display("FAIL halt_sticky got st=%0d err=%0d pc=%h cnt=%0d exp st=2 err=3 pc=80000200 cnt=11", state, err, pc, cnt); end
   endtask

   task automatic test_err_priority();
      reset_to_run();
      drive_seq(32'h8000_0000);
      default_pc = 32'd0;
      imem_err   = 1'b1;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd1 || pc !== 32'h8000_0000) begin errors++; $display("FAIL imem_priority got st=%0d err=%0d pc=%h exp st=2 err=1 pc=80000000", state, err, pc); end
      // Asynchronous reset while halted, well before the next rising edge
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h8000_0000 || state !== 2'd0 || err !== 2'd0 || cnt !== 32'd0 || valid !== 1'b0) begin errors++; $display("FAIL async_reset got pc=%h st=%0d err=%0d cnt=%0d v=%b exp pc=80000000 st=0 err=0 cnt=0 v=0", pc, state, err, cnt, valid); end
      // Misaligned and out of range together: misaligned wins
      reset_to_run();
      drive_seq(32'h8000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0002;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd3) begin errors++; $display("FAIL align_over_range got st=%0d err=%0d exp st=2 err=3", state, err); end
      // Redirect just above the legal window
      reset_to_run();
      drive_seq(32'h8000_0000);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8800_0000;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd2 || pc !== 32'h8000_0000) begin errors++; $display("FAIL range_hi got st=%0d err=%0d pc=%h exp st=2 err=2 pc=80000000", state, err, pc); end
      // Zero default PC without a redirect, even while stalled
      reset_to_run();
      drive_seq(32'h8000_0000);
      default_pc = 32'd0;
      stall      = 1'b1;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd2 || pc !== 32'h8000_0000) begin errors++; $display("FAIL default_zero got st=%0d err=%0d pc=%h exp st=2 err=2 pc=80000000", state, err, pc); end
      // Backward branch landing below PC_LO
      reset_to_run();
      drive_seq(32'h8000_0000);
      opcode = OP_BR;
      imm    = 32'hFFFF_FFFC;
      tick();
      checks++; if (state !== 2'd2 || err !== 2'd2 || pc !== 32'h8000_0000) begin errors++; $display("FAIL range_lo got st=%0d err=%0d pc=%h exp st=2 err=2 pc=80000000", state, err, pc); end
   endtask

   task automatic test_cnt_wrap();
      reset_to_run();
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt_q;
      #1;
      drive_seq(32'h8000_0000);
      tick();
      checks++; if (cnt !== 32'd0 || pc !== 32'h8000_0004) begin errors++; $display("FAIL cnt_wrap got cnt=%h pc=%h exp cnt=00000000 pc=80000004", cnt, pc); end
      drive_seq(32'h8000_0004);
      tick();
      checks++; if (cnt !== 32'd1 || pc !== 32'h8000_0008) begin errors++; $display("FAIL cnt_after_wrap got cnt=%h pc=%h exp cnt=00000001 pc=80000008", cnt, pc); end
   endtask

   initial begin
      exp_pc  = 32'h8000_0000;
      exp_cnt = 32'd0;
      rst_n   = 1'b0;
      test_reset();
      test_sequential();
      test_predict();
      test_stall_redirect();
      test_misaligned();
      test_err_priority();
      test_cnt_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
